// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit writing straight into the register file
// Define MULDIV_EARLY_OUT_EN to finish divide-by-zero and signed-overflow divides right after issue.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd_in,
  input  logic [31:0] i_op_a,
  input  logic [31:0] i_op_b,
  output logic        o_busy,
  output logic        o_rd_en,
  output logic [4:0]  o_rd,
  output logic [31:0] o_result
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_funct3;
  logic [4:0]  r_tag, r_rd, r_cnt;
  logic [31:0] r_opnd, r_special_res, r_result;
  logic [63:0] r_acc;
  logic        r_neg_q, r_neg_r, r_special;

  logic        w_in_div, w_in_sa, w_in_sb, w_neg_a, w_neg_b;
  logic        w_in_dz, w_in_ovf, w_in_special;
  logic [31:0] w_mag_a, w_mag_b, w_in_special_res;
  logic [32:0] w_mul_sum, w_rem_sh, w_diff;
  logic        w_ge;
  logic [63:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
  logic [31:0] w_quo, w_rem, w_final, w_done_res;
  logic [4:0]  w_done_rd;
  logic        w_load_out;

  // Issue-time decode: signedness, magnitudes and the two divide corner cases.
  assign w_in_div = i_funct3[2];
  assign w_in_sa  = w_in_div ? ~i_funct3[0] : (i_funct3 == 3'b001 || i_funct3 == 3'b010);
  assign w_in_sb  = w_in_div ? ~i_funct3[0] : (i_funct3 == 3'b001);
  assign w_neg_a  = w_in_sa & i_op_a[31];
  assign w_neg_b  = w_in_sb & i_op_b[31];
  assign w_mag_a  = w_neg_a ? (~i_op_a + 32'd1) : i_op_a;
  assign w_mag_b  = w_neg_b ? (~i_op_b + 32'd1) : i_op_b;
  assign w_in_dz  = w_in_div & (i_op_b == 32'd0);
  assign w_in_ovf = w_in_div & ~i_funct3[0] & (i_op_a == 32'h8000_0000) & (i_op_b == 32'hFFFF_FFFF);
  assign w_in_special     = w_in_dz | w_in_ovf;
  assign w_in_special_res = w_in_dz ? (i_funct3[1] ? i_op_a : 32'hFFFF_FFFF)
                                    : (i_funct3[1] ? 32'd0  : 32'h8000_0000);

  // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
  assign w_mul_sum = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};
  assign w_mul_nxt = {w_mul_sum, r_acc[31:1]};

  // Divide: {remainder, quotient}; remainder stays below the divisor so bit 32 of w_diff is the borrow.
  assign w_rem_sh  = r_acc[63:31];
  assign w_diff    = w_rem_sh - {1'b0, r_opnd};
  assign w_ge      = ~w_diff[32];
  assign w_div_nxt = {(w_ge ? w_diff[31:0] : w_rem_sh[31:0]), r_acc[30:0], w_ge};

  assign w_acc_nxt = r_funct3[2] ? w_div_nxt : w_mul_nxt;
  assign w_prod    = r_neg_q ? (~w_acc_nxt + 64'd1) : w_acc_nxt;
  assign w_quo     = r_neg_q ? (~w_acc_nxt[31:0] + 32'd1) : w_acc_nxt[31:0];
  assign w_rem     = r_neg_r ? (~w_acc_nxt[63:32] + 32'd1) : w_acc_nxt[63:32];
  assign w_final   = r_funct3[2] ? (r_funct3[1] ? w_rem : w_quo)
                                 : ((r_funct3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32]);

  assign w_load_out = (r_state != S_DONE) && (w_state_nxt == S_DONE);
  assign w_done_res = (r_state == S_IDLE) ? w_in_special_res : (r_special ? r_special_res : w_final);
  assign w_done_rd  = (r_state == S_IDLE) ? i_rd_in : r_tag;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
`ifdef MULDIV_EARLY_OUT_EN
          w_state_nxt = w_in_special ? S_DONE : S_CALC;
`else
          w_state_nxt = S_CALC;
`endif
        end
      end
      S_CALC:  if (r_cnt == 5'd31) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (r_state != S_IDLE);
    o_rd_en = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_funct3      <= 3'd0;
      r_tag         <= 5'd0;
      r_rd          <= 5'd0;
      r_cnt         <= 5'd0;
      r_opnd        <= 32'd0;
      r_acc         <= 64'd0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_special     <= 1'b0;
      r_special_res <= 32'd0;
      r_result      <= 32'd0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_funct3      <= i_funct3;
        r_tag         <= i_rd_in;
        r_cnt         <= 5'd0;
        r_neg_q       <= w_neg_a ^ w_neg_b;
        r_neg_r       <= w_neg_a;
        r_special     <= w_in_special;
        r_special_res <= w_in_special_res;
        r_opnd        <= w_in_div ? w_mag_b : w_mag_a;
        r_acc         <= w_in_div ? {32'd0, w_mag_a} : {32'd0, w_mag_b};
      end
      if (r_state == S_CALC) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_load_out) begin
        r_rd     <= w_done_rd;
        r_result <= w_done_res;
      end
    end
  end

  assign o_rd     = r_rd;
  assign o_result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit: directed corner cases plus random ops vs a reference model
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [4:0]  i_rd_in = 5'd0;
  logic [31:0] i_op_a = 32'd0;
  logic [31:0] i_op_b = 32'd0;
  logic        o_busy, o_rd_en;
  logic [4:0]  o_rd;
  logic [31:0] o_result;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_funct3(i_funct3),
    .i_rd_in(i_rd_in), .i_op_a(i_op_a), .i_op_b(i_op_b),
    .o_busy(o_busy), .o_rd_en(o_rd_en), .o_rd(o_rd), .o_result(o_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain wide arithmetic on the architectural definition of each funct3.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] up;
    int ia, ib;
    logic [31:0] r;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    up = {32'd0, a} * {32'd0, b};
    ia = a;
    ib = b;
    r = 32'd0;
    case (f)
      3'd0: r = up[31:0];
      3'd1: begin sp = sa * sb; r = sp[63:32]; end
      3'd2: begin sp = sa * $signed({32'd0, b}); r = sp[63:32]; end
      3'd3: r = up[63:32];
      3'd4: if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = 32'(ia / ib);
      3'd5: if (b == 0) r = 32'hFFFF_FFFF; else r = a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else r = 32'(ia % ib);
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) lat = 1;
`else
    if (f == 3'd7 && a == 32'hDEAD_BEEF && b == 32'hDEAD_BEEF) lat = 33;
`endif
    return lat;
  endfunction

  // Monitor: every write strobe must match the oldest expected write, at the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (prev_en) chk("busy_low_after_write", {31'd0, o_busy}, 32'd0);
    prev_en = (o_rd_en === 1'b1);
    if (o_rd_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_write", {27'd0, o_rd}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("write_rd", {27'd0, o_rd}, {27'd0, e.rd});
        chk("write_result", o_result, e.res);
        chk("write_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", {31'd0, o_busy}, 32'd0);
  endtask

  task automatic scramble_inputs();
    i_funct3 = 3'($urandom_range(0, 7));
    i_rd_in  = 5'($urandom_range(0, 31));
    i_op_a   = $urandom;
    i_op_b   = $urandom;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
    exp_t e;
    wait_idle();
    i_start = 1'b1; i_funct3 = f; i_op_a = a; i_op_b = b; i_rd_in = rd;
    e.rd = rd; e.res = exp; e.due = cyc + latency(f, a, b);
    sb_q.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
    scramble_inputs();
    chk("busy_after_issue", {31'd0, o_busy}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int n;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_rd_en", {31'd0, o_rd_en}, 32'd0);
    chk("reset_rd", {27'd0, o_rd}, 32'd0);
    chk("reset_result", o_result, 32'd0);
    reset = 1'b0;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    issue(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC);
    issue(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'd1);
    issue(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
    issue(3'd7, 32'd5, 32'd0, 5'd10, 32'd5);
    issue(3'd4, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF);
    issue(3'd6, 32'd5, 32'd0, 5'd12, 32'd5);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0);
    issue(3'd0, 32'd2, 32'd3, 5'd0, 32'd6);

    // Start re-asserted during CALC and DONE must be ignored.
    issue(3'd5, 32'd100, 32'd7, 5'd3, 32'd14);
    i_start = 1'b1;
    repeat (5) begin scramble_inputs(); @(negedge clk); end
    i_start = 1'b0;
    n = 0;
    while (o_rd_en !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    chk("done_reached", {31'd0, o_rd_en}, 32'd1);
    i_start = 1'b1;
    scramble_inputs();
    @(negedge clk);
    i_start = 1'b0;
    repeat (40) @(negedge clk);

    // Reset during CALC iteration 10 drops the op.
    issue(3'd0, 32'h1234, 32'h5678, 5'd20, 32'h0626_0060);
    repeat (10) @(negedge clk);
    void'(sb_q.pop_back());
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", {31'd0, o_busy}, 32'd0);
    chk("midreset_rd_en", {31'd0, o_rd_en}, 32'd0);
    chk("midreset_result", o_result, 32'd0);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4, 5'd7, 32'h0000_000C);

    // Reset beats a simultaneous start.
    wait_idle();
    reset = 1'b1; i_start = 1'b1; i_funct3 = 3'd0; i_op_a = 32'd9; i_op_b = 32'd9;
    @(negedge clk);
    reset = 1'b0; i_start = 1'b0;
    chk("reset_over_start", {31'd0, o_busy}, 32'd0);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 9) == 0) b = 32'hFFFF_FFFF;
      issue(f, a, b, 5'($urandom_range(0, 31)), model(f, a, b));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
